program_loader: RTL and testbench

Synthesizable program loader that replaces file-based memory preloading: it accepts a byte stream (for example from a UART receiver), assembles big-endian 32-bit words, and writes them into the processor's instruction or data memory through the memories' write port. It holds the MIPS processor in reset while a load is in progress and releases it only after a frame passes its checksum. It sits between the host byte source and the `Imem`/`Dmem` write ports of `MIPS_Processor`.

---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 130 +++++++++++++
 tb/tb_program_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input, memory write port and CPU-control signals of the program loader.
// The host side uses the master modport and the loader uses the slave modport.
interface program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  load_ok;
    logic                  load_err;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst, load_ok, load_err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_rst, load_ok, load_err
    );
endinterface

// File: rtl/program_loader.sv
// Frame-based program loader: assembles big-endian words from a byte stream, writes
// them into IMEM or DMEM, and holds the CPU in reset until a frame checksum matches.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    program_loader_if.slave        bus
);
    localparam logic [7:0] CMD_IMEM = 8'hA5;
    localparam logic [7:0] CMD_DMEM = 8'h5A;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHECK
    } state_e;

    state_e                 state_q;
    logic                   tgt_imem_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [1:0]             byte_cnt_q;
    logic [31:0]            asm_q;
    logic [7:0]             sum_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   in_ready_q;
    logic                   imem_we_q;
    logic                   dmem_we_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [31:0]            mem_wdata_q;
    logic                   cpu_rst_q;
    logic                   load_ok_q;
    logic                   load_err_q;
    logic                   accept;
    logic [31:0]            word_full;

    assign accept    = bus.in_valid && in_ready_q;
    assign word_full = {asm_q[23:0], bus.in_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tgt_imem_q  <= 1'b0;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            sum_q       <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.in_data == CMD_IMEM || bus.in_data == CMD_DMEM) begin
                            tgt_imem_q <= (bus.in_data == CMD_IMEM);
                            cpu_rst_q  <= 1'b1;
                            addr_q     <= '0;
                            sum_q      <= '0;
                            state_q    <= S_CNT_HI;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end
                    S_CNT_HI: begin
                        cnt_q[15:8] <= bus.in_data;
                        sum_q       <= sum_q + bus.in_data;
                        state_q     <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        cnt_q[7:0] <= bus.in_data;
                        sum_q      <= sum_q + bus.in_data;
                        byte_cnt_q <= '0;
                        state_q    <= ({cnt_q[15:8], bus.in_data} == '0) ? S_CHECK : S_DATA;
                    end
                    S_DATA: begin
                        sum_q      <= sum_q + bus.in_data;
                        asm_q      <= word_full;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Fourth byte completes a word: present it on the write port next cycle.
                        if (byte_cnt_q == 2'd3) begin
                            mem_wdata_q <= word_full;
                            mem_addr_q  <= addr_q;
                            imem_we_q   <= tgt_imem_q;
                            dmem_we_q   <= !tgt_imem_q;
                            addr_q      <= addr_q + ADDR_WIDTH'(1);
                            cnt_q       <= cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (bus.in_data == sum_q) begin
                            load_ok_q <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.imem_we   = imem_we_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.load_ok   = load_ok_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboard of expected memory writes and
// load status pulses, driven by a directed sequence of frames.
module tb_program_loader;
    localparam int unsigned AW = 2;

    typedef struct {
        bit          imem;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit ok;
        bit err;
        bit cpu_rst;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   exp_cpu_rst = 1'b1;

    wr_t         wq[$];
    st_t         sq[$];
    logic [31:0] frame_words[$];

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.imem_we || bus.dmem_we) begin
            wr_t w;
            check("we_exclusive", 32'(bus.imem_we && bus.dmem_we), 32'd0);
            if (wq.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                w = wq.pop_front();
                check("we_target", 32'(bus.imem_we), 32'(w.imem));
                check("we_addr", 32'(bus.mem_addr), 32'(w.addr));
                check("we_data", bus.mem_wdata, w.data);
            end
        end
        if (bus.load_ok || bus.load_err) begin
            st_t s;
            if (sq.size() == 0) begin
                check("spurious_status", 32'd1, 32'd0);
            end else begin
                s = sq.pop_front();
                check("status", {29'd0, bus.load_ok, bus.load_err, bus.cpu_rst},
                      {29'd0, s.ok, s.err, s.cpu_rst});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a frame with the words in frame_words; model expectations are queued as bytes go out.
    task automatic send_frame(input logic [7:0] cmd, input int gap, input bit bad_chk);
        logic [15:0] n;
        logic [7:0]  sum;
        logic [7:0]  b;
        wr_t         w;
        st_t         s;
        n   = 16'(frame_words.size());
        sum = n[15:8] + n[7:0];
        send(cmd);
        send(n[15:8]);
        send(n[7:0]);
        for (int i = 0; i < frame_words.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b   = frame_words[i][31-8*k -: 8];
                sum = sum + b;
                if (k == 3) begin
                    w.imem = (cmd == 8'hA5);
                    w.addr = AW'(i % (1 << AW));
                    w.data = frame_words[i];
                    wq.push_back(w);
                end
                send(b);
                idle(gap);
            end
        end
        exp_cpu_rst = bad_chk;
        s.ok = !bad_chk;
        s.err = bad_chk;
        s.cpu_rst = bad_chk;
        sq.push_back(s);
        send(bad_chk ? sum + 8'd1 : sum);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && (wq.size() != 0 || sq.size() != 0); i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check(tag, 32'(wq.size() + sq.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"}, {30'd0, bus.imem_we, bus.dmem_we}, 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_status"}, {30'd0, bus.load_ok, bus.load_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t s;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
        check("cpu_rst_after_release", 32'(bus.cpu_rst), 32'd1);
        @(posedge clk);
        #1;

        // IMEM load, back-to-back bytes
        frame_words = '{32'h2008_0005, 32'h2009_0007};
        send_frame(8'hA5, 0, 1'b0);
        drain("drain_imem");
        check("imem_cpu_rst", 32'(bus.cpu_rst), 32'd0);

        // DMEM load with 2 idle cycles between bytes
        frame_words = '{32'hDEAD_BEEF};
        send_frame(8'h5A, 2, 1'b0);
        drain("drain_dmem");
        check("dmem_cpu_rst", 32'(bus.cpu_rst), 32'd0);

        // Checksum error: words still written, cpu held in reset
        frame_words = '{32'h2008_0005, 32'h2009_0007};
        send_frame(8'hA5, 0, 1'b1);
        drain("drain_chk_err");
        check("chk_err_cpu_rst", 32'(bus.cpu_rst), 32'd1);

        // Bad command leaves FSM idle and cpu_rst unchanged
        s.ok = 1'b0;
        s.err = 1'b1;
        s.cpu_rst = exp_cpu_rst;
        sq.push_back(s);
        send(8'h11);
        drain("drain_bad_cmd");
        check("bad_cmd_cpu_rst", 32'(bus.cpu_rst), 32'(exp_cpu_rst));

        // Zero-count frame: no writes, load_ok
        frame_words.delete();
        send_frame(8'hA5, 0, 1'b0);
        drain("drain_zero");
        check("zero_cpu_rst", 32'(bus.cpu_rst), 32'd0);

        // Address wrap: 5 words into a 4-word space, fifth lands at 0
        frame_words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
        send_frame(8'h5A, 0, 1'b0);
        drain("drain_wrap");
        check("wrap_last_addr", 32'(bus.mem_addr), 32'd0);
        check("wrap_last_data", bus.mem_wdata, 32'h5555_0004);

        // Mid-frame reset after 2 data bytes
        send(8'hA5);
        send(8'h00);
        send(8'h05);
        send(8'h12);
        send(8'h34);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        check_reset_values("midreset_hold");
        rst = 1'b1;
        idle(3);
        drain("drain_midreset");
        check("midreset_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
